// File: rtl/spi_pkg_master_rx.sv
// SPI master that pulls one fixed-size package from a slave after its interrupt edge.
// Mode 0 (CPOL=0, CPHA=0), MSB first, with per-byte strobes and sticky overrun/timeout flags.
module spi_pkg_master_rx #(
  parameter int PKG_SIZE   = 60,
  parameter int SCK_HALF   = 4,
  parameter int BYTE_GAP   = 2,
  parameter int CS_TIMEOUT = 1024
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        intr_in,
  input  logic        cs_n_in,
  input  logic        miso,
  output logic        sck,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic [15:0] byte_cnt,
  output logic        pkg_done,
  output logic        busy,
  output logic        overrun,
  output logic        timeout
);

  typedef enum logic [2:0] {IDLE, WAIT_CS, XFER, LATCH, GAP, DONE} state_t;

  localparam logic [15:0] PKG_LAST  = 16'(PKG_SIZE - 1);
  localparam logic [31:0] HALF_LAST = 32'(SCK_HALF - 1);
  localparam logic [31:0] GAP_LAST  = (BYTE_GAP > 0) ? 32'(BYTE_GAP - 1) : 32'd0;
  localparam logic [31:0] TMO_LAST  = 32'(CS_TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic        intr_meta, intr_sync, intr_prev;
  logic        cs_meta, cs_sync;
  logic [31:0] cnt_reg, cnt_next;
  logic [2:0]  bit_reg, bit_next;
  logic [7:0]  shift_reg, shift_next;
  logic        sck_reg, sck_next;
  logic [7:0]  rx_data_reg, rx_data_next;
  logic        rx_valid_reg, rx_valid_next;
  logic [15:0] byte_cnt_reg, byte_cnt_next;
  logic        pkg_done_reg, pkg_done_next;
  logic        overrun_reg, overrun_next;
  logic        timeout_reg, timeout_next;
  logic        intr_rise, start_byte;

  assign intr_rise = intr_sync & ~intr_prev;

  // Synchronisers; cs_n idles high so its chain resets to 1.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      intr_meta <= 1'b0;
      intr_sync <= 1'b0;
      intr_prev <= 1'b0;
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
    end else begin
      intr_meta <= intr_in;
      intr_sync <= intr_meta;
      intr_prev <= intr_sync;
      cs_meta   <= cs_n_in;
      cs_sync   <= cs_meta;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      bit_reg      <= '0;
      shift_reg    <= '0;
      sck_reg      <= 1'b0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      byte_cnt_reg <= '0;
      pkg_done_reg <= 1'b0;
      overrun_reg  <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      bit_reg      <= bit_next;
      shift_reg    <= shift_next;
      sck_reg      <= sck_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
      byte_cnt_reg <= byte_cnt_next;
      pkg_done_reg <= pkg_done_next;
      overrun_reg  <= overrun_next;
      timeout_reg  <= timeout_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    bit_next      = bit_reg;
    shift_next    = shift_reg;
    sck_next      = sck_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;
    byte_cnt_next = byte_cnt_reg;
    pkg_done_next = 1'b0;
    overrun_next  = overrun_reg;
    timeout_next  = timeout_reg;
    start_byte    = 1'b0;

    if (state_reg != IDLE && intr_rise)
      overrun_next = 1'b1;

    case (state_reg)
      IDLE: begin
        if (intr_rise) begin
          state_next    = WAIT_CS;
          cnt_next      = '0;
          byte_cnt_next = '0;
          overrun_next  = 1'b0;
          timeout_next  = 1'b0;
        end
      end
      WAIT_CS: begin
        if (!cs_sync)
          start_byte = 1'b1;
        else if (cnt_reg == TMO_LAST) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end else
          cnt_next = cnt_reg + 32'd1;
      end
      XFER: begin
        if (cs_sync) begin
          state_next = IDLE;
          sck_next   = 1'b0;
        end else if (cnt_reg == HALF_LAST) begin
          cnt_next = '0;
          if (sck_reg) begin
            sck_next = 1'b0;
            if (bit_reg == 3'd7)
              state_next = LATCH;
          end else begin
            // Rising edge: sample miso in the same cycle sck goes high.
            sck_next   = 1'b1;
            shift_next = {shift_reg[6:0], miso};
            bit_next   = bit_reg + 3'd1;
          end
        end else
          cnt_next = cnt_reg + 32'd1;
      end
      LATCH: begin
        rx_data_next  = shift_reg;
        rx_valid_next = 1'b1;
        byte_cnt_next = byte_cnt_reg + 16'd1;
        cnt_next      = '0;
        if (byte_cnt_reg == PKG_LAST) begin
          pkg_done_next = 1'b1;
          state_next    = DONE;
        end else if (BYTE_GAP == 0)
          start_byte = 1'b1;
        else
          state_next = GAP;
      end
      GAP: begin
        if (cs_sync)
          state_next = IDLE;
        else if (cnt_reg == GAP_LAST)
          start_byte = 1'b1;
        else
          cnt_next = cnt_reg + 32'd1;
      end
      DONE: begin
        if (cs_sync)
          state_next = IDLE;
        else if (cnt_reg == TMO_LAST) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end else
          cnt_next = cnt_reg + 32'd1;
      end
      default: state_next = IDLE;
    endcase

    // Every byte begins with an immediate sck rise and first-bit sample.
    if (start_byte) begin
      state_next = XFER;
      sck_next   = 1'b1;
      shift_next = {shift_reg[6:0], miso};
      bit_next   = '0;
      cnt_next   = '0;
    end
  end

  assign sck      = sck_reg;
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;
  assign byte_cnt = byte_cnt_reg;
  assign pkg_done = pkg_done_reg;
  assign busy     = (state_reg != IDLE);
  assign overrun  = overrun_reg;
  assign timeout  = timeout_reg;

endmodule

// File: tb/tb_spi_pkg_master_rx.sv
// Directed bench for spi_pkg_master_rx: a mode-0 slave model feeds packages while
// a monitor collects rx bytes, pkg_done strobes and sck rise times.
module tb_spi_pkg_master_rx;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        intr_in = 1'b0;
  logic        cs_n_in = 1'b1;
  logic        miso;
  logic        sck;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] byte_cnt;
  logic        pkg_done;
  logic        busy;
  logic        overrun;
  logic        timeout;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] pkg_data [0:59];
  logic [7:0] rx_q [$];
  int         rise_q [$];
  int         done_cnt = 0;
  logic [7:0] done_byte = 8'h00;
  int         base_rx, base_done, base_rise;

  spi_pkg_master_rx dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .intr_in   (intr_in),
    .cs_n_in   (cs_n_in),
    .miso      (miso),
    .sck       (sck),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .byte_cnt  (byte_cnt),
    .pkg_done  (pkg_done),
    .busy      (busy),
    .overrun   (overrun),
    .timeout   (timeout)
  );

  always #10 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Slave: presents MSB while cs_n high, advances one bit after each sck fall.
  int   s_bit = 0;
  int   s_byte = 0;
  logic s_sck_prev = 1'b0;
  logic [7:0] s_cur;
  always @(negedge sys_clk) begin
    if (cs_n_in) begin
      s_bit = 0;
      s_byte = 0;
    end else if (s_sck_prev && !sck) begin
      if (s_bit == 7) begin
        s_bit = 0;
        s_byte++;
      end else
        s_bit++;
    end
    s_sck_prev = sck;
    s_cur = (s_byte < 60) ? pkg_data[s_byte] : 8'h00;
    miso = s_cur[7 - s_bit];
  end

  logic m_sck_prev = 1'b0;
  always @(negedge sys_clk) begin
    if (rx_valid) rx_q.push_back(rx_data);
    if (pkg_done) begin
      done_cnt++;
      done_byte = rx_data;
    end
    if (sck && !m_sck_prev) rise_q.push_back(cyc);
    m_sck_prev = sck;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else
      $display("ok   %s: 0x%0h", tag, obs);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sck"},      32'(sck), 0);
    check({tag, "_rx_data"},  32'(rx_data), 0);
    check({tag, "_rx_valid"}, 32'(rx_valid), 0);
    check({tag, "_byte_cnt"}, 32'(byte_cnt), 0);
    check({tag, "_pkg_done"}, 32'(pkg_done), 0);
    check({tag, "_busy"},     32'(busy), 0);
    check({tag, "_overrun"},  32'(overrun), 0);
    check({tag, "_timeout"},  32'(timeout), 0);
  endtask

  // One package: intr pulse, cs_n low, optional overrun/abort/reset injection at a byte count.
  task automatic run_pkg(input int abort_at, input int ovr_at, input int rst_at);
    int n;
    int ovr_hold;
    bit ovr_done;
    bit abort_done;
    ovr_hold = 0;
    ovr_done = 0;
    abort_done = 0;
    base_rx = rx_q.size();
    base_done = done_cnt;
    base_rise = rise_q.size();
    @(posedge sys_clk); #1 intr_in = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 intr_in = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("busy_acc", 32'(busy), 1);
    check("ovr_clr", 32'(overrun), 0);
    check("tmo_clr", 32'(timeout), 0);
    check("cnt_clr", 32'(byte_cnt), 0);
    cs_n_in = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1 check("sck_lat2", 32'(sck), 0);
    @(posedge sys_clk);
    #1 check("sck_lat3", 32'(sck), 1);
    n = 0;
    while (busy && (done_cnt == base_done) && n < 20000) begin
      @(posedge sys_clk);
      #1;
      n++;
      if (ovr_hold > 0) begin
        ovr_hold--;
        if (ovr_hold == 0) intr_in = 1'b0;
      end
      if (!ovr_done && (rx_q.size() - base_rx) == ovr_at) begin
        intr_in = 1'b1;
        ovr_hold = 3;
        ovr_done = 1;
      end
      if (!abort_done && (rx_q.size() - base_rx) == abort_at) begin
        cs_n_in = 1'b1;
        abort_done = 1;
      end
      if ((rx_q.size() - base_rx) == rst_at) begin
        repeat (6) @(posedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1 check_zero("rst_mid");
        return;
      end
    end
    check("in_time", 32'(n < 20000), 1);
    if (!abort_done) begin
      repeat (2) @(posedge sys_clk);
      #1 cs_n_in = 1'b1;
      n = 0;
      while (busy && n < 20) begin
        @(posedge sys_clk);
        #1;
        n++;
      end
    end
    check("idle_after", 32'(busy), 0);
    intr_in = 1'b0;
  endtask

  task automatic check_full(input string tag);
    check({tag, "_nbytes"}, 32'(rx_q.size() - base_rx), 60);
    check({tag, "_ndone"}, 32'(done_cnt - base_done), 1);
    check({tag, "_done_byte"}, 32'(done_byte), 32'h3B);
    check({tag, "_byte_cnt"}, 32'(byte_cnt), 60);
    for (int i = 0; i < 60 && (base_rx + i) < rx_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), 32'(rx_q[base_rx + i]), 32'(i));
  endtask

  initial begin
    int n;
    for (int i = 0; i < 60; i++) pkg_data[i] = 8'(i);
    repeat (3) @(posedge sys_clk);
    #1 check_zero("reset");
    sys_rst_n = 1'b1;
    repeat (3) @(posedge sys_clk);

    // Full package 0x00..0x3B.
    run_pkg(-1, -1, -1);
    check_full("pkg1");
    check("cnt_hold", 32'(byte_cnt), 60);

    // MSB-first pattern and sck period.
    pkg_data[0] = 8'hA5;
    pkg_data[1] = 8'h5A;
    run_pkg(-1, -1, -1);
    check("pat_a5", 32'(rx_q[base_rx]), 32'hA5);
    check("pat_5a", 32'(rx_q[base_rx + 1]), 32'h5A);
    check("sck_period", 32'(rise_q[base_rise + 1] - rise_q[base_rise]), 8);
    pkg_data[0] = 8'h00;
    pkg_data[1] = 8'h01;

    // cs_n never asserted: timeout after CS_TIMEOUT cycles.
    base_rx = rx_q.size();
    base_rise = rise_q.size();
    @(posedge sys_clk); #1 intr_in = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 intr_in = 1'b0;
    repeat (1000) @(posedge sys_clk);
    #1;
    check("tmo_wait_busy", 32'(busy), 1);
    check("tmo_wait_flag", 32'(timeout), 0);
    n = 0;
    while (busy && n < 200) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    check("tmo_flag", 32'(timeout), 1);
    check("tmo_busy", 32'(busy), 0);
    check("tmo_sck", 32'(rise_q.size() - base_rise), 0);
    check("tmo_rx", 32'(rx_q.size() - base_rx), 0);

    // Second intr edge at byte 10.
    run_pkg(-1, 10, -1);
    check("ovr_flag", 32'(overrun), 1);
    check_full("pkg_ovr");

    // Abort after byte 20.
    run_pkg(20, -1, -1);
    check("abort_cnt", 32'(byte_cnt), 20);
    check("abort_rx", 32'(rx_q.size() - base_rx), 20);
    check("abort_done", 32'(done_cnt - base_done), 0);

    // Reset during byte 5, then a clean package.
    run_pkg(-1, -1, 5);
    #5 cs_n_in = 1'b1;
    intr_in = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    repeat (4) @(posedge sys_clk);
    run_pkg(-1, -1, -1);
    check_full("pkg_post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
